// File: rtl/lfsr_word_sched.sv
// lfsr_word_sched: one Fibonacci LFSR time-shared among NREQ requesters.
// A pending request is granted (round-robin by default), the LFSR advances
// STEPS times, and the resulting word is delivered with a one-cycle gnt pulse.
//
// Build option: define LFSR_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// pending index wins, no rotating pointer). Undefined: round-robin.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-low reset
//   req        one-cycle request pulses, one bit per requester
//   seed_load  load seed_val into the LFSR (honoured in IDLE only)
//   seed_val   seed value (zero is replaced by 1)
//   gnt        one-hot, one-cycle pulse on delivery
//   data       delivered word, held until the next delivery
//   busy       high whenever the scheduler is not IDLE
module lfsr_word_sched #(
  parameter int unsigned      NREQ   = 4,
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(16'b1000000001011),
  parameter logic             INVERT = 1'b0,
  parameter int unsigned      STEPS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DELIVER
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [WIDTH-1:0] data_d;
  logic [NREQ-1:0]  gnt_d;
  logic             busy_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic             fb;
`ifdef LFSR_SCHED_FIXED_PRIO_EN
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  // One Fibonacci step: parity of tapped bits shifts in at the MSB
  always_comb begin
    fb        = (^(lfsr_q & TAPS)) ^ INVERT;
    lfsr_step = {fb, lfsr_q[WIDTH-1:1]};
  end

  // Winner selection over the registered pending vector
  always_comb begin
    found = 1'b0;
    pick  = '0;
`ifdef LFSR_SCHED_FIXED_PRIO_EN
    // Descending scan so the lowest pending index is the last to assign
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pending_q[IDX_W'(i)]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
`else
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && pending_q[IDX_W'((int'(ptr_q) + k) % int'(NREQ))]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    data_d    = data;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    gnt_d     = '0;
    // A request arriving with its own grant keeps the bit set
    pending_d = (pending_q & ~gnt) | req;
`ifdef LFSR_SCHED_FIXED_PRIO_EN
`else
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_val == '0) ? WIDTH'(1) : seed_val;
        end else if (found) begin
          winner_d = pick;
          cnt_d    = CNT_W'(STEPS - 1);
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        lfsr_d = lfsr_step;
        if (cnt_q == '0) begin
          data_d  = lfsr_step;
          gnt_d   = NREQ'(1) << winner_q;
          state_d = S_DELIVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DELIVER: begin
`ifdef LFSR_SCHED_FIXED_PRIO_EN
`else
        if (int'(winner_q) == int'(NREQ) - 1) ptr_d = '0;
        else                                  ptr_d = winner_q + IDX_W'(1);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= WIDTH'(1);
      data      <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      pending_q <= '0;
      cnt_q     <= '0;
      winner_q  <= '0;
`ifdef LFSR_SCHED_FIXED_PRIO_EN
`else
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      data      <= data_d;
      gnt       <= gnt_d;
      busy      <= busy_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
`ifdef LFSR_SCHED_FIXED_PRIO_EN
`else
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_word_sched.sv
// Testbench for lfsr_word_sched (default round-robin build).
// A transaction-level reference model predicts gnt/busy/data each cycle;
// a second instance with STEPS=4 covers the short-transaction case.
module tb_lfsr_word_sched;
  localparam int          NREQ  = 4;
  localparam int          STEPS = 16;
  localparam logic [15:0] TAPS  = 16'b1000000001011;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req4;
  logic        seed_load;
  logic [15:0] seed_val;
  logic        seed_load4 = 1'b0;
  logic [15:0] seed_val4  = 16'h0;
  logic [3:0]  gnt, gnt4;
  logic [15:0] data, data4;
  logic        busy, busy4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_word_sched dut (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load),
    .seed_val(seed_val), .gnt(gnt), .data(data), .busy(busy)
  );

  lfsr_word_sched #(.STEPS(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .seed_load(seed_load4),
    .seed_val(seed_val4), .gnt(gnt4), .data(data4), .busy(busy4)
  );

  // Reference model: transaction bookkeeping in terms of cycles remaining
  logic [3:0]  m_pending;
  int          m_ptr, m_w, m_left;
  bit          m_active;
  logic [15:0] m_lfsr, m_word;
  logic [3:0]  e_gnt;
  logic        e_busy;
  logic [15:0] e_data;

  function automatic logic [15:0] advance(input logic [15:0] s, input int n);
    logic [15:0] v = s;
    for (int i = 0; i < n; i++) begin
      int par = $countones(v & TAPS) % 2;
      v = (v >> 1) | (16'(par) << 15);
    end
    return v;
  endfunction

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_outputs();
    e_gnt  = (m_active && m_left == 0) ? 4'(1 << m_w) : 4'b0000;
    e_busy = m_active;
  endtask

  task automatic model_reset();
    m_pending = '0; m_ptr = 0; m_w = 0; m_left = 0; m_active = 0;
    m_lfsr = 16'h0001; m_word = '0; e_data = '0;
    model_outputs();
  endtask

  task automatic model_update(input logic [3:0] r, input logic sl, input logic [15:0] sv);
    logic [3:0] np;
    np = (m_pending & ~e_gnt) | r;
    if (m_active) begin
      if (m_left == 0) begin
        m_active = 0;
        m_ptr    = (m_w + 1) % NREQ;
      end else begin
        m_left--;
        if (m_left == 0) e_data = m_word;
      end
    end else if (sl) begin
      m_lfsr = (sv == 16'h0) ? 16'h0001 : sv;
    end else if (m_pending != 0) begin
      m_w      = rr_pick(m_pending, m_ptr);
      m_lfsr   = advance(m_lfsr, STEPS);
      m_word   = m_lfsr;
      m_active = 1;
      m_left   = STEPS;
    end
    m_pending = np;
    model_outputs();
  endtask

  // Drive one cycle of inputs; returns #1 after the edge that sampled them
  task automatic step(input logic [3:0] r, input logic sl, input logic [15:0] sv);
    req = r; seed_load = sl; seed_val = sv;
    model_update(r, sl, sv);
    @(posedge clk); #1;
    req = '0; seed_load = 1'b0; seed_val = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; req4 = '0; seed_load = 1'b0; seed_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_chk++;
    if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int bc = 0;
    do_reset();
    step(4'b0001, 1'b0, '0);
    for (int i = 1; i <= 22; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL single cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      if (busy) bc++;
      if (i == 18) begin
        n_chk++;
        if (gnt !== 4'b0001 || data !== 16'hB111) begin
          n_fail++;
          $display("FAIL single_word: got gnt %b data %h want 0001 B111", gnt, data);
        end
      end
      step('0, 1'b0, '0);
    end
    n_chk++;
    if (bc != 17) begin n_fail++; $display("FAIL single_busy_len: got %0d want 17", bc); end
  endtask

  task automatic test_steps4();
    do_reset();
    req4 = 4'b0100;
    step('0, 1'b0, '0);
    req4 = '0;
    for (int i = 1; i <= 8; i++) begin
      n_chk++;
      if (i == 6) begin
        if (gnt4 !== 4'b0100 || data4 !== 16'h1000) begin
          n_fail++;
          $display("FAIL steps4_word: got gnt %b data %h want 0100 1000", gnt4, data4);
        end
      end else if (gnt4 !== 4'b0000) begin
        n_fail++;
        $display("FAIL steps4_gnt cyc%0d: got %b want 0000", i, gnt4);
      end
      step('0, 1'b0, '0);
    end
  endtask

  task automatic test_all_four();
    int         gt[$];
    logic [3:0] gv[$];
    logic [3:0] r;
    bit         sent = 0;
    logic [3:0] want_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    step(4'b1111, 1'b0, '0);
    for (int i = 1; i <= 100; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL all4 cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      if (gnt != 0) begin gt.push_back(i); gv.push_back(gnt); end
      r = '0;
      if (e_gnt[3] && !sent) begin r = 4'b0001; sent = 1; end
      step(r, 1'b0, '0);
    end
    n_chk++;
    if (gt.size() != 5) begin
      n_fail++;
      $display("FAIL all4_count: got %0d grants want 5", gt.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (gv[k] !== want_v[k] || gt[k] != 18 * (k + 1)) begin
          n_fail++;
          $display("FAIL all4_order #%0d: got %b at %0d want %b at %0d",
                   k, gv[k], gt[k], want_v[k], 18 * (k + 1));
        end
      end
    end
  endtask

  task automatic test_seed_zero();
    do_reset();
    step(4'b0001, 1'b0, '0);
    repeat (19) step('0, 1'b0, '0);
    // Pending and seed together: seed wins, arbitration slips a cycle
    step(4'b0010, 1'b0, '0);
    step('0, 1'b1, 16'h0000);
    for (int i = 2; i <= 21; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL seed0 cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      if (i == 19) begin
        n_chk++;
        if (gnt !== 4'b0010 || data !== 16'hB111) begin
          n_fail++;
          $display("FAIL seed0_word: got gnt %b data %h want 0010 B111", gnt, data);
        end
      end
      step('0, 1'b0, '0);
    end
  endtask

  task automatic test_seed_busy();
    do_reset();
    step(4'b0001, 1'b0, '0);
    for (int i = 1; i <= 20; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL seedbusy cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      if (i == 18) begin
        n_chk++;
        if (data !== 16'hB111) begin
          n_fail++;
          $display("FAIL seedbusy_word: got %h want B111", data);
        end
      end
      if (i >= 3 && i <= 17) step('0, 1'b1, 16'($urandom_range(1, 65535)));
      else                   step('0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'b0010, 1'b0, '0);
    repeat (6) step('0, 1'b0, '0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({gnt, busy, data} !== {4'b0000, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL resetmid_now: gnt/busy/data got %b/%b/%h want 0000/0/0000", gnt, busy, data);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      n_chk++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL resetmid_quiet cyc%0d: gnt/busy got %b/%b want 0000/0", i, gnt, busy);
      end
      step('0, 1'b0, '0);
    end
    step(4'b0010, 1'b0, '0);
    for (int i = 1; i <= 18; i++) begin
      if (i == 18) begin
        n_chk++;
        if (gnt !== 4'b0010 || data !== 16'hB111) begin
          n_fail++;
          $display("FAIL resetmid_word: got gnt %b data %h want 0010 B111", gnt, data);
        end
      end
      step('0, 1'b0, '0);
    end
  endtask

  task automatic test_regrant();
    int gt[$];
    logic [3:0] r;
    bit sent = 0;
    do_reset();
    step(4'b0010, 1'b0, '0);
    for (int i = 1; i <= 45; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL regrant cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      if (gnt === 4'b0010) gt.push_back(i);
      r = '0;
      if (e_gnt[1] && !sent) begin r = 4'b0010; sent = 1; end
      step(r, 1'b0, '0);
    end
    n_chk++;
    if (gt.size() != 2 || gt[0] != 18 || gt[1] != 36) begin
      n_fail++;
      $display("FAIL regrant_times: got %0d grants (first %0d) want 2 at 18,36",
               gt.size(), (gt.size() > 0) ? gt[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [3:0]  r;
    logic        sl;
    logic [15:0] sv;
    do_reset();
    for (int i = 0; i < 900; i++) begin
      n_chk++;
      if ({gnt, busy, data} !== {e_gnt, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL random cyc%0d: gnt/busy/data got %b/%b/%h want %b/%b/%h",
                 i, gnt, busy, data, e_gnt, e_busy, e_data);
      end
      r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      sl = ($urandom_range(0, 11) == 0);
      sv = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      step(r, sl, sv);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_steps4();
    test_all_four();
    test_seed_zero();
    test_seed_busy();
    test_reset_mid();
    test_regrant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_word_sched.md
# lfsr_word_sched

Shared pseudo-random word scheduler: one Fibonacci LFSR, time-shared among NREQ requesters. Each request is granted in round-robin order. The LFSR advances STEPS times per grant, and the resulting WIDTH-bit word is delivered with a one-cycle grant pulse. It sits between the scrambler/test-pattern clients and the single LFSR resource, so consumers never drive the LFSR enable directly.

## Interface
- NREQ, 4 — number of requesters, 2..8
- WIDTH, 16 — LFSR and data width
- TAPS, 16'b1000000001011 — feedback tap mask, WIDTH bits
- INVERT, 0 — XORed into the feedback bit
- STEPS, 16 — LFSR advances per delivered word, 1..255
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req  in  NREQ  one-cycle request pulses, one bit per requester
- seed_load  in  1  load seed_val into the LFSR (IDLE only)
- seed_val  in  WIDTH  seed value
- gnt  out  NREQ  one-hot, one-cycle pulse when a word is delivered
- data  out  WIDTH  delivered word, held until the next delivery
- busy  out  1  high whenever state is not IDLE

## Operation
- LFSR step:
  - fb = ^(lfsr & TAPS) ^ INVERT
  - lfsr <= {fb, lfsr[WIDTH-1:1]}
- Pending register, NREQ bits:
  - A req[i] pulse sets pending[i].
  - pending[i] clears on the cycle gnt[i] is high, unless req[i] is also high that cycle, in which case it stays set.
  - A req[i] pulse while pending[i] is already set is absorbed; there is no queue depth.
- FSM states: IDLE, STEP, DELIVER.
- IDLE:
  - If seed_load: lfsr <= (seed_val == 0) ? 1 : seed_val. Stay IDLE; no arbitration that cycle.
  - Else if pending != 0:
    - Select a winner round-robin, searching ptr, ptr+1, … modulo NREQ.
    - Register the winner.
    - Set cnt <= STEPS-1 and go to STEP.
- STEP:
  - The LFSR steps every cycle.
  - If cnt == 0: data <= next LFSR value, go to DELIVER. Otherwise cnt <= cnt-1.
- DELIVER:
  - gnt[winner] = 1 for this cycle only.
  - ptr <= (winner+1) mod NREQ.
  - Go to IDLE.
- seed_load outside IDLE is ignored, not queued.
- The LFSR never steps outside STEP.
- data changes only on entry to DELIVER.

## Timing
- Reset values:
  - lfsr = 1, data = 0, gnt = 0, busy = 0
  - pending = 0, ptr = 0, cnt = 0, state IDLE
- Reset mid-transaction:
  - All state returns to reset values immediately.
  - No gnt is issued for the aborted transaction.
  - Pending requests are lost.
- Latency: a req pulse in cycle c0 gives gnt high in cycle c0+STEPS+2. The +2 covers the pending capture into IDLE, then the arbitration edge.
- Back-to-back grants are spaced exactly STEPS+2 cycles apart: DELIVER, IDLE, then STEPS cycles of STEP.
- busy is high in the winner-selection cycle's successor through DELIVER inclusive, i.e. for STEPS+1 cycles.
- Simultaneous events:
  - Multiple pending bits: one winner per transaction; the others wait.
  - seed_load together with pending in IDLE: the seed wins and arbitration is delayed one cycle.
- Wrap-around: after granting NREQ-1, ptr returns to 0.

## Configuration
- LFSR_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority, where the lowest-index pending requester always wins. ptr and its update logic are removed.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then req[0] pulse, default params:
  - gnt = 4'b0001 exactly 18 cycles later, data = 16'hB111.
  - busy high for 17 cycles.
- STEPS=4, reset, req[2] pulse:
  - gnt[2] after 6 cycles, data = 16'h1000.
- All four req pulsed in the same cycle:
  - Grants in order 0,1,2,3, each 18 cycles apart.
  - A fifth req[0] pulse issued during the grant to 3 is served next.
- seed_load with seed_val = 0 in IDLE:
  - The LFSR reloads with 1.
  - The next word equals the post-reset word (16'hB111).
- seed_load while busy is ignored, and data matches the unseeded sequence.
- Reset asserted mid-STEP for requester 1:
  - No gnt appears.
  - data = 0 and busy = 0 immediately.
  - The next req[1] yields 16'hB111.
- req[1] pulsed in the same cycle as gnt[1]:
  - pending[1] stays set.
  - A second gnt[1] follows STEPS+2 cycles later.
